// File: rtl/bus_grant_arbiter_if.sv
// bus_grant_arbiter_if
// Bundles the request/grant signals between the bus sources and the
// round-robin bus arbiter.
//   req      : per-source drive request (level)
//   done     : current owner has finished its transfer
//   grant    : one-hot drive enable for the bus-select encoder
//   grant_id : binary index of the owner, 31 when idle
//   busy     : a grant is active
//   timeout  : one-cycle pulse when an owner is forcibly revoked
// Modports: master = request side (drives req/done),
//           slave  = arbiter side (drives grant/grant_id/busy/timeout).
interface bus_grant_arbiter_if;
  logic [31:0] req;
  logic        done;
  logic [31:0] grant;
  logic [4:0]  grant_id;
  logic        busy;
  logic        timeout;

  modport master (
    output req, done,
    input  grant, grant_id, busy, timeout
  );

  modport slave (
    input  req, done,
    output grant, grant_id, busy, timeout
  );
endinterface

// File: rtl/bus_grant_arbiter.sv
// bus_grant_arbiter
// Round-robin arbiter for the shared 32-bit datapath bus. Issues a registered
// one-hot grant, inserts one dead cycle between owners, and revokes an owner
// that holds the bus for HOLD_MAX cycles (that source is then locked out until
// it drops and re-raises its request).
// Ports:
//   clock : system clock, rising edge
//   clear : synchronous active-low reset
//   bus   : bus_grant_arbiter_if.slave (req, done in; grant, grant_id,
//           busy, timeout out; all outputs registered)
module bus_grant_arbiter #(
  parameter int NUM_SRC  = 24,
  parameter int HOLD_MAX = 16
) (
  input  logic                clock,
  input  logic                clear,
  bus_grant_arbiter_if.slave  bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;
  localparam logic [4:0] ID_IDLE  = 5'd31;

  logic [0:0]  state_reg,    state_next;
  logic [31:0] grant_reg,    grant_next;
  logic [4:0]  grant_id_reg, grant_id_next;
  logic        busy_reg,     busy_next;
  logic        timeout_reg,  timeout_next;
  logic [4:0]  rr_ptr_reg,   rr_ptr_next;
  logic [7:0]  hold_cnt_reg, hold_cnt_next;
  logic [31:0] penalty_reg,  penalty_next;

  logic [31:0] eligible;
  logic        found;
  logic [4:0]  winner;
  logic        revoke;

  // Per-source eligibility and penalty update. Bits at or above NUM_SRC are
  // tied off so they can never win or be penalised. A penalty is dropped on
  // any edge where that source's request is low; it is only ever set while
  // the request is high, so the two never collide.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_src
      if (gi < NUM_SRC) begin : g_live
        assign eligible[gi]     = bus.req[gi] & ~penalty_reg[gi];
        assign penalty_next[gi] = bus.req[gi] &
                                  (penalty_reg[gi] | (revoke & (grant_id_reg == 5'(gi))));
      end else begin : g_dead
        assign eligible[gi]     = 1'b0;
        assign penalty_next[gi] = 1'b0;
      end
    end
  endgenerate

  // Round-robin search: walk offsets from the far end back toward rr_ptr so
  // the last hit is the first eligible source at or above rr_ptr (with wrap).
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      logic [5:0] cand;
      cand = {1'b0, rr_ptr_reg} + 6'(k);
      if (cand >= 6'(NUM_SRC)) cand = cand - 6'(NUM_SRC);
      if (eligible[cand[4:0]]) begin
        found  = 1'b1;
        winner = cand[4:0];
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    grant_id_next = grant_id_reg;
    busy_next     = busy_reg;
    timeout_next  = 1'b0;
    rr_ptr_next   = rr_ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    revoke        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (found) begin
          state_next    = ST_GRANT;
          grant_next    = 32'd1 << winner;
          grant_id_next = winner;
          busy_next     = 1'b1;
          hold_cnt_next = '0;
          rr_ptr_next   = (winner == 5'(NUM_SRC - 1)) ? 5'd0 : winner + 5'd1;
        end
      end
      default: begin
        // done and a withdrawn request both take priority over the hold
        // limit, so a simultaneous done never counts as a timeout.
        if (bus.done || !bus.req[grant_id_reg]) begin
          state_next    = ST_IDLE;
          grant_next    = '0;
          grant_id_next = ID_IDLE;
          busy_next     = 1'b0;
        end else if (hold_cnt_reg == 8'(HOLD_MAX - 1)) begin
          state_next    = ST_IDLE;
          grant_next    = '0;
          grant_id_next = ID_IDLE;
          busy_next     = 1'b0;
          timeout_next  = 1'b1;
          revoke        = 1'b1;
        end else begin
          hold_cnt_next = hold_cnt_reg + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_reg    <= ST_IDLE;
      grant_reg    <= '0;
      grant_id_reg <= ID_IDLE;
      busy_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
      rr_ptr_reg   <= '0;
      hold_cnt_reg <= '0;
      penalty_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      grant_id_reg <= grant_id_next;
      busy_reg     <= busy_next;
      timeout_reg  <= timeout_next;
      rr_ptr_reg   <= rr_ptr_next;
      hold_cnt_reg <= hold_cnt_next;
      penalty_reg  <= penalty_next;
    end
  end

  assign bus.grant    = grant_reg;
  assign bus.grant_id = grant_id_reg;
  assign bus.busy     = busy_reg;
  assign bus.timeout  = timeout_reg;

endmodule

// File: doc/bus_grant_arbiter.md
# bus_grant_arbiter

Round-robin arbiter for the single shared 32-bit datapath bus. Collects drive requests from up to 24 bus sources (R0–R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort, C_sign_extended, at bit positions 0–23) and issues a registered one-hot grant word. This block sits directly upstream of the 32-to-5 bus-select encoder. It guarantees that at most one grant bit is ever set and that the bus sees one dead cycle between owners.

## Interface
Parameters:
- NUM_SRC, 24: number of arbitrated sources (bits 0..NUM_SRC-1). Legal range 2..31.
- HOLD_MAX, 16: maximum consecutive cycles one owner may hold the bus before forced revoke. Legal range 2..255.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  reset; synchronous, active-low.
- req  in  32  per-source drive request, level-sensitive. Bits ≥ NUM_SRC are ignored.
- done  in  1  current owner finished; sampled only while a grant is active.
- grant  out  32  one-hot drive enable to the encoder/bus; all-zero when idle.
- grant_id  out  5  binary index of the current owner; 5'd31 when idle.
- busy  out  1  high while any grant bit is set.
- timeout  out  1  one-cycle pulse on forced revoke.

## Operation
- Reset state (clear=0 at an edge): state=IDLE, grant=0, grant_id=31, busy=0, timeout=0, rr_ptr=0, hold_cnt=0, penalty mask=0. Reset overrides every other event, including reset in the middle of a grant.
- States: IDLE and GRANT.
- IDLE: eligible = req[NUM_SRC-1:0] & ~penalty. If eligible≠0, the winner is the first set bit searching upward from rr_ptr with wrap (NUM_SRC-1 → 0). The next state is GRANT: grant=1<<winner, grant_id=winner, busy=1, hold_cnt=0, rr_ptr=(winner+1) mod NUM_SRC. If eligible=0, the block stays IDLE with all outputs idle.
- GRANT, each edge, evaluated in priority order:
  1. done=1 → release.
  2. req[owner]=0 → release; a withdrawn request is treated as done.
  3. hold_cnt==HOLD_MAX-1 → forced revoke: release, timeout=1 for this cycle, set penalty[owner].
  4. Otherwise hold_cnt++.
- Release: grant=0, grant_id=31, busy=0, next state IDLE. No owner is granted on the same edge.
- Penalty: penalty[i] clears on any edge where req[i]=0. A penalized source is not eligible until it drops and then reasserts req.
- grant and grant_id are always consistent: popcount(grant)≤1, and grant_id=31 iff grant=0.
- rr_ptr advances only on a new grant, never on release or timeout.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- req→grant latency from IDLE: 1 edge. req seen at edge N gives grant valid after edge N.
- done at edge N → grant=0 after N. The earliest next grant is after edge N+1, so the bus gets exactly 1 dead cycle between owners.
- Maximum tenure: HOLD_MAX cycles with grant high. timeout is high for exactly the first cycle with grant=0.
- Requests raised while another source is granted are not serviced early. They compete at the next IDLE edge.
- done asserted in IDLE is ignored.
- Simultaneous done and timeout condition: treated as a normal release, with no timeout and no penalty.

## Test plan
- Reset: hold clear=0 for 2 edges with req=32'hFFFFFFFF → grant=0, grant_id=31, busy=0, timeout=0. After release, the first grant goes to bit 0.
- Single request: req=32'h00100000 (PC) → after 1 edge grant=32'h00100000, grant_id=20. Pulse done → next cycle grant=0, grant_id=31.
- Round-robin fairness: hold req=32'h00000022 (R1, R5) and pulse done each tenure → grants alternate R1, R5, R1… Each grant is separated by one cycle with grant=0.
- Timeout: req=32'h00000008 held, done never asserted → grant stays high for 16 cycles, then grant=0 and timeout=1 for one cycle. R3 is not regranted until req[3] drops and rises again.
- Ignored bits and withdrawal: req=32'hFF000000 → stays idle. req=32'h00000400 is granted, then req drops to 0 without done → release on the next edge with timeout=0.
- Reset mid-grant: owner R7 granted, clear=0 for one edge → grant=0, grant_id=31. The next arbitration starts from rr_ptr=0.
